// File: rtl/crop_scheduler_if.sv
// Stream bundle between crop_scheduler and its neighbours: request source,
// pixel source, the external crop_filter and the cropped-pixel sink.
interface crop_scheduler_if #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
);
  logic [IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH-1:0] req_TDATA;
  logic                                         req_TVALID;
  logic                                         req_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  src_pixel_TDATA;
  logic                        src_pixel_TVALID;
  logic                        src_pixel_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  filt_pixel_in_TDATA;
  logic                        filt_pixel_in_TVALID;
  logic                        filt_pixel_in_TREADY;

  logic [IMG_ROW_BITWIDTH-1:0] filt_crop_Y1_TDATA;
  logic                        filt_crop_Y1_TVALID;
  logic                        filt_crop_Y1_TREADY;

  logic [IMG_COL_BITWIDTH-1:0] filt_crop_X1_TDATA;
  logic                        filt_crop_X1_TVALID;
  logic                        filt_crop_X1_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  filt_pixel_out_TDATA;
  logic                        filt_pixel_out_TVALID;
  logic                        filt_pixel_out_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA;
  logic                        pixel_out_TVALID;
  logic                        pixel_out_TLAST;
  logic                        pixel_out_TREADY;

  // The scheduler side
  modport master (
    input  req_TDATA, req_TVALID,
    output req_TREADY,
    input  src_pixel_TDATA, src_pixel_TVALID,
    output src_pixel_TREADY,
    output filt_pixel_in_TDATA, filt_pixel_in_TVALID,
    input  filt_pixel_in_TREADY,
    output filt_crop_Y1_TDATA, filt_crop_Y1_TVALID,
    input  filt_crop_Y1_TREADY,
    output filt_crop_X1_TDATA, filt_crop_X1_TVALID,
    input  filt_crop_X1_TREADY,
    input  filt_pixel_out_TDATA, filt_pixel_out_TVALID,
    output filt_pixel_out_TREADY,
    output pixel_out_TDATA, pixel_out_TVALID, pixel_out_TLAST,
    input  pixel_out_TREADY
  );

  // The environment side (sources, filter and sink)
  modport slave (
    output req_TDATA, req_TVALID,
    input  req_TREADY,
    output src_pixel_TDATA, src_pixel_TVALID,
    input  src_pixel_TREADY,
    input  filt_pixel_in_TDATA, filt_pixel_in_TVALID,
    output filt_pixel_in_TREADY,
    input  filt_crop_Y1_TDATA, filt_crop_Y1_TVALID,
    output filt_crop_Y1_TREADY,
    input  filt_crop_X1_TDATA, filt_crop_X1_TVALID,
    output filt_crop_X1_TREADY,
    output filt_pixel_out_TDATA, filt_pixel_out_TVALID,
    input  filt_pixel_out_TREADY,
    input  pixel_out_TDATA, pixel_out_TVALID, pixel_out_TLAST,
    output pixel_out_TREADY
  );
endinterface

// File: rtl/crop_scheduler.sv
// Queues (Y1,X1) crop requests and runs one frame through crop_filter per request.
// Optional macro CROP_SCHEDULER_CLAMP_EN clamps loaded coordinates into the frame.
module crop_scheduler #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int REQ_DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  crop_scheduler_if.master     bus,
  output logic                 busy,
  output logic                 crop_done,
  output logic [15:0]          crops_completed
);

  localparam int REQ_W     = IMG_ROW_BITWIDTH + IMG_COL_BITWIDTH;
  localparam int IN_TOTAL  = IN_ROWS * IN_COLS;
  localparam int OUT_TOTAL = OUT_ROWS * OUT_COLS;
  localparam int IN_CW     = $clog2(IN_TOTAL + 1);
  localparam int OUT_CW    = $clog2(OUT_TOTAL + 1);
  localparam int PTR_W     = $clog2(REQ_DEPTH);
  localparam int CNT_W     = $clog2(REQ_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, CFG, STREAM, DONE} state_t;

  state_t                       state, next_state;
  logic [REQ_W-1:0]             fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count, count_after;
  logic [IMG_ROW_BITWIDTH-1:0]  y1;
  logic [IMG_COL_BITWIDTH-1:0]  x1;
  logic                         y1_done, x1_done;
  logic [IN_CW-1:0]             in_cnt;
  logic [OUT_CW-1:0]            out_cnt;
  logic                         push, pop, load, in_ok, out_ok, in_hs, out_hs;
  logic                         stream, y1_hs, x1_hs;
  logic [REQ_W-1:0]             load_src, load_req;

  function automatic logic [REQ_W-1:0] clamp_req(input logic [REQ_W-1:0] r);
`ifdef CROP_SCHEDULER_CLAMP_EN
    localparam logic [IMG_ROW_BITWIDTH-1:0] Y_MAX = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
    localparam logic [IMG_COL_BITWIDTH-1:0] X_MAX = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);
    logic [IMG_ROW_BITWIDTH-1:0] y;
    logic [IMG_COL_BITWIDTH-1:0] x;
    y = r[REQ_W-1:IMG_COL_BITWIDTH];
    x = r[IMG_COL_BITWIDTH-1:0];
    if (y > Y_MAX) y = Y_MAX;
    if (x > X_MAX) x = X_MAX;
    return {y, x};
`else
    return r;
`endif
  endfunction

  assign bus.req_TREADY = reset & (count < CNT_W'(REQ_DEPTH));
  assign push           = bus.req_TVALID & bus.req_TREADY;
  assign pop            = (state == DONE);
  assign count_after    = count + CNT_W'(push) - CNT_W'(pop);

  // Leaving DONE the next head is either the entry behind the popped one or,
  // when that slot is empty, the request being pushed in this same cycle.
  always_comb begin
    load_src = fifo_mem[rd_ptr];
    if (state == DONE) begin
      if (count > CNT_W'(1)) load_src = fifo_mem[rd_ptr + PTR_W'(1)];
      else                   load_src = bus.req_TDATA;
    end
  end

  assign load     = ((state == IDLE) && (count != '0)) ||
                    ((state == DONE) && (count_after != '0));
  assign load_req = clamp_req(load_src);

  assign stream = (state == STREAM);
  assign in_ok  = in_cnt < IN_CW'(IN_TOTAL);
  assign out_ok = out_cnt < OUT_CW'(OUT_TOTAL);
  assign in_hs  = stream & in_ok & bus.src_pixel_TVALID & bus.filt_pixel_in_TREADY;
  assign out_hs = stream & out_ok & bus.filt_pixel_out_TVALID & bus.pixel_out_TREADY;

  assign bus.filt_pixel_in_TDATA   = bus.src_pixel_TDATA;
  assign bus.filt_pixel_in_TVALID  = stream & in_ok & bus.src_pixel_TVALID;
  assign bus.src_pixel_TREADY      = stream & in_ok & bus.filt_pixel_in_TREADY;
  assign bus.pixel_out_TDATA       = bus.filt_pixel_out_TDATA;
  assign bus.pixel_out_TVALID      = stream & out_ok & bus.filt_pixel_out_TVALID;
  assign bus.filt_pixel_out_TREADY = stream & out_ok & bus.pixel_out_TREADY;
  assign bus.pixel_out_TLAST       = stream & out_ok & (out_cnt == OUT_CW'(OUT_TOTAL - 1));

  assign bus.filt_crop_Y1_TDATA  = y1;
  assign bus.filt_crop_X1_TDATA  = x1;
  assign bus.filt_crop_Y1_TVALID = (state == CFG) & ~y1_done;
  assign bus.filt_crop_X1_TVALID = (state == CFG) & ~x1_done;
  assign y1_hs = bus.filt_crop_Y1_TVALID & bus.filt_crop_Y1_TREADY;
  assign x1_hs = bus.filt_crop_X1_TVALID & bus.filt_crop_X1_TREADY;

  assign busy      = (state != IDLE);
  assign crop_done = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = CFG;
      CFG:     if (y1_done && x1_done) next_state = STREAM;
      STREAM:  if ((in_cnt == IN_CW'(IN_TOTAL)) && (out_cnt == OUT_CW'(OUT_TOTAL)))
                 next_state = DONE;
      DONE:    next_state = (count_after != '0) ? CFG : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.req_TDATA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

  // Done flags are sticky through CFG so each coordinate is sent exactly once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1      <= '0;
      x1      <= '0;
      y1_done <= 1'b0;
      x1_done <= 1'b0;
    end else begin
      if (load) begin
        y1 <= load_req[REQ_W-1:IMG_COL_BITWIDTH];
        x1 <= load_req[IMG_COL_BITWIDTH-1:0];
      end
      if (state != CFG) begin
        y1_done <= 1'b0;
        x1_done <= 1'b0;
      end else begin
        if (y1_hs) y1_done <= 1'b1;
        if (x1_hs) x1_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt          <= '0;
      out_cnt         <= '0;
      crops_completed <= '0;
    end else if (state == DONE) begin
      in_cnt          <= '0;
      out_cnt         <= '0;
      crops_completed <= crops_completed + 16'd1;
    end else begin
      if (in_hs)  in_cnt  <= in_cnt + IN_CW'(1);
      if (out_hs) out_cnt <= out_cnt + OUT_CW'(1);
    end
  end

endmodule

// File: tb/tb_crop_scheduler.sv
// Randomized bench for crop_scheduler: the bench plays source, filter and sink,
// and a request-queue model predicts coordinates, beat counts and completions.
module tb_crop_scheduler;

  localparam int PW = 16, RW = 10, CW = 10;
  localparam int IN_ROWS = 12, IN_COLS = 20, OUT_ROWS = 4, OUT_COLS = 6, DEPTH = 4;
  localparam int IN_TOTAL  = IN_ROWS * IN_COLS;
  localparam int OUT_TOTAL = OUT_ROWS * OUT_COLS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy, crop_done;
  logic [15:0] crops_completed;

  crop_scheduler_if #(.PIXEL_BIT_WIDTH(PW), .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW)) bus ();

  crop_scheduler #(
    .PIXEL_BIT_WIDTH(PW), .IN_ROWS(IN_ROWS), .IN_COLS(IN_COLS),
    .OUT_ROWS(OUT_ROWS), .OUT_COLS(OUT_COLS),
    .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW), .REQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .crop_done(crop_done), .crops_completed(crops_completed)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Expected coordinates the filter should receive for a request
  function automatic logic [RW+CW-1:0] modelReq(input logic [RW+CW-1:0] d);
    int y, x;
    y = int'(d[RW+CW-1:CW]);
    x = int'(d[CW-1:0]);
`ifdef CROP_SCHEDULER_CLAMP_EN
    if (y > IN_ROWS - OUT_ROWS) y = IN_ROWS - OUT_ROWS;
    if (x > IN_COLS - OUT_COLS) x = IN_COLS - OUT_COLS;
`endif
    return {RW'(y), CW'(x)};
  endfunction

  logic [RW+CW-1:0] expq[$];
  int      doneTotal = 0;
  int      inBeats = 0, outBeats = 0, yCount = 0, xCount = 0;
  int      tlastErr = 0, dataErr = 0, protoErr = 0;
  logic [RW-1:0] yVal = '0;
  logic [CW-1:0] xVal = '0;
  bit      afterDone = 0;
  bit      srcHs = 0, foutHs = 0;
  bit      cfgStall = 0, xStall = 0;

  // Monitor: observes every handshake mid-cycle and scores each finished crop
  always @(negedge clk) begin
    logic [RW+CW-1:0] expReq;
    if (!reset) begin
      expq.delete();
      doneTotal = 0; inBeats = 0; outBeats = 0; yCount = 0; xCount = 0;
      tlastErr = 0; dataErr = 0; protoErr = 0; afterDone = 0;
      srcHs = 0; foutHs = 0;
    end else begin
      if (afterDone) begin
        checkOutput("crops_completed", crops_completed, doneTotal);
        checkOutput("busy_after_done", busy, expq.size() != 0);
        afterDone = 0;
      end
      srcHs  = bus.src_pixel_TVALID & bus.src_pixel_TREADY;
      foutHs = bus.filt_pixel_out_TVALID & bus.filt_pixel_out_TREADY;
      if (bus.req_TVALID & bus.req_TREADY) expq.push_back(modelReq(bus.req_TDATA));
      if (bus.filt_crop_Y1_TVALID & bus.filt_crop_Y1_TREADY) begin
        yCount++; yVal = bus.filt_crop_Y1_TDATA;
      end
      if (bus.filt_crop_X1_TVALID & bus.filt_crop_X1_TREADY) begin
        xCount++; xVal = bus.filt_crop_X1_TDATA;
      end
      if (srcHs != (bus.filt_pixel_in_TVALID & bus.filt_pixel_in_TREADY)) protoErr++;
      if (bus.filt_pixel_in_TVALID & bus.filt_pixel_in_TREADY) begin
        inBeats++;
        if (bus.filt_pixel_in_TDATA !== bus.src_pixel_TDATA) dataErr++;
      end
      if (foutHs != (bus.pixel_out_TVALID & bus.pixel_out_TREADY)) protoErr++;
      if (bus.pixel_out_TVALID & bus.pixel_out_TREADY) begin
        outBeats++;
        if (bus.pixel_out_TLAST !== (outBeats == OUT_TOTAL)) tlastErr++;
        if (bus.pixel_out_TDATA !== bus.filt_pixel_out_TDATA) dataErr++;
      end
      if ((bus.filt_crop_Y1_TVALID | bus.filt_crop_X1_TVALID) &
          (bus.filt_pixel_in_TVALID | bus.pixel_out_TVALID)) protoErr++;
      if ((bus.filt_crop_Y1_TVALID | bus.filt_crop_X1_TVALID |
           bus.filt_pixel_in_TVALID | bus.pixel_out_TVALID) & !busy) protoErr++;
      if (crop_done) begin
        checkOutput("request_pending_at_done", expq.size() != 0, 1);
        expReq = (expq.size() != 0) ? expq.pop_front() : '0;
        checkOutput("crop_y1", yVal, expReq[RW+CW-1:CW]);
        checkOutput("crop_x1", xVal, expReq[CW-1:0]);
        checkOutput("y1_handshakes", yCount, 1);
        checkOutput("x1_handshakes", xCount, 1);
        checkOutput("input_beats", inBeats, IN_TOTAL);
        checkOutput("output_beats", outBeats, OUT_TOTAL);
        checkOutput("tlast_errors", tlastErr, 0);
        checkOutput("data_errors", dataErr, 0);
        checkOutput("protocol_errors", protoErr, 0);
        doneTotal++;
        afterDone = 1;
        inBeats = 0; outBeats = 0; yCount = 0; xCount = 0;
        tlastErr = 0; dataErr = 0; protoErr = 0;
      end
    end
  end

  // Source, filter and sink behaviour with random throttling; valids hold until accepted
  initial begin
    bus.src_pixel_TVALID      = 1'b0;
    bus.src_pixel_TDATA       = '0;
    bus.filt_pixel_out_TVALID = 1'b0;
    bus.filt_pixel_out_TDATA  = '0;
    bus.filt_pixel_in_TREADY  = 1'b0;
    bus.pixel_out_TREADY      = 1'b0;
    bus.filt_crop_Y1_TREADY   = 1'b0;
    bus.filt_crop_X1_TREADY   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.src_pixel_TVALID || srcHs) begin
        bus.src_pixel_TVALID = ($urandom_range(0, 3) != 0);
        bus.src_pixel_TDATA  = PW'($urandom);
      end
      if (!bus.filt_pixel_out_TVALID || foutHs) begin
        bus.filt_pixel_out_TVALID = ($urandom_range(0, 3) != 0);
        bus.filt_pixel_out_TDATA  = PW'($urandom);
      end
      bus.filt_pixel_in_TREADY = ($urandom_range(0, 3) != 0);
      bus.pixel_out_TREADY     = ($urandom_range(0, 3) != 0);
      bus.filt_crop_Y1_TREADY  = !cfgStall && ($urandom_range(0, 1) == 1);
      bus.filt_crop_X1_TREADY  = !cfgStall && !xStall && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic applyStimulus(input int y, input int x);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.req_TVALID = 1'b1;
    bus.req_TDATA  = {RW'(y), CW'(x)};
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_TREADY) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (ok) begin @(posedge clk); #1; end
    bus.req_TVALID = 1'b0;
    checkOutput("req_accepted", ok, 1);
  endtask

  task automatic waitCrops(input int target);
    for (int i = 0; i < 3000 * 6; i++) begin
      @(negedge clk);
      if (doneTotal >= target) break;
    end
    checkOutput("crops_finished", doneTotal, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok, prevDone, bad, gotY;
    bus.req_TVALID = 1'b0;
    bus.req_TDATA  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_req_tready", bus.req_TREADY, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_crop_done", crop_done, 0);
    checkOutput("reset_crops_completed", crops_completed, 0);
    checkOutput("reset_tvalids", {bus.filt_crop_Y1_TVALID, bus.filt_crop_X1_TVALID,
                bus.filt_pixel_in_TVALID, bus.pixel_out_TVALID, bus.pixel_out_TLAST}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", bus.req_TREADY, 1);

    $display("[TB] single request");
    applyStimulus(37, 59);
    waitCrops(1);

    $display("[TB] three queued requests");
    applyStimulus(0, 0);
    applyStimulus(52, 112);
    applyStimulus(37, 59);
    waitCrops(4);

    $display("[TB] request FIFO full with filter stalled in CFG");
    cfgStall = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    @(negedge clk);
    checkOutput("fifo_full_ready", bus.req_TREADY, 0);
    @(posedge clk); #1;
    bus.req_TVALID = 1'b1;
    bus.req_TDATA  = {RW'($urandom_range(0, 1023)), CW'($urandom_range(0, 1023))};
    cfgStall = 0;
    ok = 0; prevDone = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_TREADY) begin
        ok = 1;
        checkOutput("push_cycle_after_pop", prevDone, 1);
      end else begin
        prevDone = crop_done;
        @(posedge clk); #1;
      end
    end
    checkOutput("fifth_req_accepted", ok, 1);
    @(posedge clk); #1;
    bus.req_TVALID = 1'b0;
    waitCrops(9);

    $display("[TB] X1 channel held off after Y1");
    xStall = 1;
    applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    gotY = 0;
    for (int i = 0; i < 500 && !gotY; i++) begin
      @(negedge clk);
      if (bus.filt_crop_Y1_TVALID & bus.filt_crop_Y1_TREADY) gotY = 1;
    end
    checkOutput("y1_accepted_during_x_stall", gotY, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.filt_crop_Y1_TVALID | !bus.filt_crop_X1_TVALID |
          bus.filt_pixel_in_TVALID | bus.pixel_out_TVALID) bad = 1;
    end
    checkOutput("x1_stall_hold", bad, 0);
    xStall = 0;
    waitCrops(10);

    $display("[TB] random requests with random gaps");
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 300)) @(posedge clk);
      applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    waitCrops(15);

    $display("[TB] reset in the middle of streaming");
    applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    applyStimulus($urandom_range(0, 1023), $urandom_range(0, 1023));
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (outBeats >= OUT_TOTAL / 2) break;
    end
    checkOutput("reached_mid_stream", outBeats >= OUT_TOTAL / 2, 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset_tvalids", {bus.filt_crop_Y1_TVALID, bus.filt_crop_X1_TVALID,
                bus.filt_pixel_in_TVALID, bus.pixel_out_TVALID, bus.pixel_out_TLAST}, 0);
    checkOutput("midreset_req_tready", bus.req_TREADY, 0);
    checkOutput("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy | crop_done) bad = 1;
    end
    checkOutput("fifo_empty_after_reset", bad, 0);
    checkOutput("crops_completed_after_reset", crops_completed, 0);

    $display("[TB] out-of-range coordinates");
    applyStimulus(80, 150);
    waitCrops(1);
    checkOutput("protocol_errors_final", protoErr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/crop_scheduler.md
Name: crop_scheduler

Overview:
Sequences `crop_filter` across a queue of crop requests. Buffers (Y1,X1) requests in a small FIFO and programs `crop_filter` through its `crop_Y1`/`crop_X1` streams. For each request it gates exactly one input frame into the filter and forwards exactly one cropped frame out, marked with TLAST. Sits between the pixel source, the request source and `crop_filter`, which is instantiated externally.

Parameters:
PIXEL_BIT_WIDTH, 16, pixel data width
IN_ROWS, 100, input frame rows
IN_COLS, 160, input frame columns
OUT_ROWS, 48, crop rows
OUT_COLS, 48, crop columns
IMG_ROW_BITWIDTH, 10, Y1 width
IMG_COL_BITWIDTH, 10, X1 width
REQ_DEPTH, 4, request FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_TDATA  in  IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH  {Y1,X1}, Y1 in MSBs
req_TVALID  in  1  request valid
req_TREADY  out  1  FIFO not full
src_pixel_TDATA/TVALID  in  PIXEL_BIT_WIDTH/1  upstream pixels
src_pixel_TREADY  out  1  upstream ready
filt_pixel_in_TDATA/TVALID  out  PIXEL_BIT_WIDTH/1  to filter
filt_pixel_in_TREADY  in  1  from filter
filt_crop_Y1_TDATA/TVALID  out  IMG_ROW_BITWIDTH/1  Y1 to filter
filt_crop_Y1_TREADY  in  1
filt_crop_X1_TDATA/TVALID  out  IMG_COL_BITWIDTH/1  X1 to filter
filt_crop_X1_TREADY  in  1
filt_pixel_out_TDATA/TVALID  in  PIXEL_BIT_WIDTH/1  filter output
filt_pixel_out_TREADY  out  1
pixel_out_TDATA/TVALID/TLAST  out  PIXEL_BIT_WIDTH/1/1  cropped stream
pixel_out_TREADY  in  1
busy  out  1  state != IDLE
crop_done  out  1  one-cycle pulse per completed crop
crops_completed  out  16  wrapping completed-crop count

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, all counters 0. Outputs: all TVALIDs 0, `req_TREADY`=0 while in reset, TLAST=0, `busy`=0, `crop_done`=0, `crops_completed`=0. Reset mid-crop abandons the crop; no `crop_done` pulse.
- Request FIFO: push on `req_TVALID & req_TREADY`. `req_TREADY` = count<REQ_DEPTH, computed from the registered count. A pop in DONE does not free a slot until the next cycle. Push and pop in the same cycle are legal when not full.
- FSM: IDLE -> CFG when the FIFO is non-empty (head registered into Y1/X1).
- CFG: `filt_crop_Y1_TVALID` and `filt_crop_X1_TVALID` are asserted independently. Each drops after its own handshake; a sticky done bit is kept per channel. CFG -> STREAM in the cycle after both are done, including when both complete in the same cycle.
- STREAM, input gating:
  - in_ok = in_cnt < IN_ROWS*IN_COLS.
  - `filt_pixel_in_TVALID` = `src_pixel_TVALID` & in_ok.
  - `src_pixel_TREADY` = `filt_pixel_in_TREADY` & in_ok.
  - TDATA passes through combinationally; in_cnt increments per handshake.
- STREAM, output gating:
  - out_ok = out_cnt < OUT_ROWS*OUT_COLS.
  - `pixel_out_TVALID` = `filt_pixel_out_TVALID` & out_ok.
  - `filt_pixel_out_TREADY` = `pixel_out_TREADY` & out_ok.
  - TLAST = out_ok & (out_cnt == OUT_ROWS*OUT_COLS-1).
- STREAM -> DONE when both counters reach their totals; the two may finish in any order.
- DONE (1 cycle): `crop_done`=1, FIFO pop, `crops_completed`+=1 (wraps at 2^16), counters cleared. Next state is CFG if the FIFO is still non-empty after the pop, otherwise IDLE. Back-to-back crops therefore have no IDLE gap.
- In IDLE/CFG/DONE all pixel TVALID/TREADY outputs are 0.
- Counter widths: $clog2(total+1).

Optional Feature:
Macro: `CROP_SCHEDULER_CLAMP_EN`.
- Defined: Y1 is clamped to IN_ROWS-OUT_ROWS and X1 to IN_COLS-OUT_COLS as the FIFO head is loaded.
- Undefined: coordinates are forwarded unmodified.

Test Plan:
- Single request {Y1=37,X1=59}, random handshakes -> filter sees Y1=37, X1=59 once each; exactly 16000 input beats and 2304 output beats; TLAST only on beat 2304; one `crop_done`; `crops_completed`=1.
- Three requests (0,0),(52,112),(37,59) queued before frame 1 -> three sequential crops in order; `crop_done` x3; DONE->CFG with no IDLE cycle between crops.
- Push 5 requests with the filter stalled in CFG (REQ_DEPTH=4) -> `req_TREADY`=0 after the 4th push; 5th accepted only in the cycle after the first DONE pop.
- `filt_crop_X1_TREADY` held low 10 cycles after the Y1 handshake -> `filt_crop_Y1_TVALID` stays 0, no pixel TVALID until X1 accepted, then STREAM.
- reset=0 mid-STREAM at out beat 1000 -> all TVALIDs 0 immediately; FIFO empty; `crops_completed` unchanged at 0; no `crop_done`.
- With CLAMP_EN, request {Y1=80,X1=150} -> filter receives Y1=52, X1=112; without CLAMP_EN -> receives 80, 150.
